// File: rtl/neuron_accumulator.sv
// Sums bias plus N_INPUTS signed products in a wide accumulator, then saturates/ReLUs to IN_W.
// Result one edge after the last product; no backpressure: product_valid is taken whenever accumulating.
module neuron_accumulator #(
  parameter int N_INPUTS = 784,
  parameter int IN_W     = 26,
  parameter int ACC_W    = 36,
  parameter int CNT_W    = 10
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   start,
  input  logic signed [IN_W-1:0] bias_in,
  input  logic signed [IN_W-1:0] product_in,
  input  logic                   product_valid,
  input  logic                   relu_en,
  output logic                   busy,
  output logic signed [IN_W-1:0] sum_out,
  output logic                   sum_valid,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(N_INPUTS - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    relu_q;

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [IN_W-1:0]  sat;
  logic signed [IN_W-1:0]  result;

  assign bias_ext = {{(ACC_W-IN_W){bias_in[IN_W-1]}}, bias_in};
  assign prod_ext = {{(ACC_W-IN_W){product_in[IN_W-1]}}, product_in};

  // ReLU acts on the already-clamped value, so a clamped negative still reads as zero.
  always_comb begin
    sat_hi = (acc > SAT_MAX);
    sat_lo = (acc < SAT_MIN);
    sat    = acc[IN_W-1:0];
    if (sat_hi) sat = SAT_MAX[IN_W-1:0];
    if (sat_lo) sat = SAT_MIN[IN_W-1:0];
    result = (relu_q && sat[IN_W-1]) ? '0 : sat;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      relu_q    <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      // start restarts from any state and discards whatever was in flight
      if (start) begin
        acc    <= bias_ext;
        count  <= '0;
        relu_q <= relu_en;
        state  <= ACCUM;
      end else begin
        case (state)
          IDLE: ;
          ACCUM: begin
            if (product_valid) begin
              acc   <= acc + prod_ext;
              count <= count + CNT_W'(1);
              if (count == LAST) state <= DONE;
            end
          end
          DONE: begin
            sum_out   <= result;
            overflow  <= sat_hi | sat_lo;
            sum_valid <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
Downstream stage of the fixed-point weight×pixel multiplier. It consumes the multiplier's sfix26_En18 product stream for one neuron, adds the neuron bias, and sums all N_INPUTS products in a wide accumulator. It then saturates the result back to sfix26_En18, optionally applies ReLU, and presents it with a one-cycle valid pulse to the next layer or the argmax stage.

Parameters:
N_INPUTS, 784, products per neuron (one per pixel); legal range ≥ 1
IN_W, 26, product/bias/output width (sfix26_En18)
ACC_W, 36, accumulator width = IN_W + ceil(log2(N_INPUTS+1))
CNT_W, 10, product counter width; must satisfy 2^CNT_W ≥ N_INPUTS

Ports:
clk  in  1  single system clock, rising edge
GlobalReset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a new neuron, loads bias_in
bias_in  in  IN_W  neuron bias, sfix26_En18, sampled only when start=1
product_in  in  IN_W  multiplier product, sfix26_En18
product_valid  in  1  product_in is valid this cycle
relu_en  in  1  apply ReLU to the result; sampled with start
busy  out  1  high in ACCUM and DONE states
sum_out  out  IN_W  saturated (and optionally ReLU'd) neuron result, sfix26_En18
sum_valid  out  1  one-cycle pulse, sum_out is valid
overflow  out  1  saturation occurred for this result; valid with sum_valid, held until next sum_valid

Behaviour:
- Reset (GlobalReset=0, asynchronous): state=IDLE, acc=0, count=0, sum_out=0, sum_valid=0, overflow=0, busy=0, latched relu=0. Takes effect immediately, including mid-accumulation. A partial sum is discarded with no sum_valid.
- State IDLE:
  - start=1 → acc <= sign-extend(bias_in) to ACC_W, count <= 0, relu latch <= relu_en, go to ACCUM.
  - product_valid is ignored in IDLE, including the same cycle as start.
- State ACCUM:
  - Each edge with product_valid=1: acc <= acc + sign-extend(product_in), count <= count+1.
  - product_valid=0 cycles (gaps) hold acc and count.
  - On the edge accepting product number N_INPUTS (count == N_INPUTS-1): go to DONE.
- State DONE (one cycle), on its edge:
  - sat = acc clamped to [-2^25, 2^25-1]; overflow <= (acc outside that range).
  - sum_out <= (latched relu && sat<0) ? 0 : sat. ReLU is applied after saturation.
  - sum_valid <= 1; go to IDLE.
  - product_valid in DONE is ignored.
- Latency: if the last product is sampled at edge k, sum_out, sum_valid and overflow update at edge k+1. sum_valid clears at edge k+2 unless a new result completes.
- start while busy (ACCUM or DONE) aborts and restarts: bias is reloaded, count is cleared, the relu latch is updated, state goes to ACCUM, and no sum_valid is produced for the aborted neuron. A product_valid on the same cycle as that start is ignored. start has priority over product_valid and over DONE completion.
- Arithmetic is two's complement throughout. ACC_W guarantees no internal wrap for N_INPUTS products plus bias.
- sum_out and overflow hold their last values between pulses.
- busy is combinational from state.

Test Plan:
- Reset: assert GlobalReset=0 mid-run (after 2 products) → sum_out=0, sum_valid=0, overflow=0, busy=0 immediately. After release with no start, no sum_valid ever appears.
- Basic sum (N_INPUTS=4): bias=262144 (1.0), products 262144, 524288, -131072, 65536 (1.0, 2.0, -0.5, 0.25) → sum_out=983040 (3.75), overflow=0. sum_valid high exactly one cycle, at the edge after the 4th product.
- Gaps and ignores (N_INPUTS=4): same stimulus with product_valid low for 3 cycles between products, plus one product_valid asserted with start → identical result 983040. The start-cycle product is not counted.
- ReLU: bias=-786432 (-3.0), products 4×65536 (0.25) → relu_en=0 gives sum_out=-524288; relu_en=1 gives sum_out=0, overflow=0.
- Saturation (default N_INPUTS=784): bias=0, all products 33554431 → sum_out=33554431, overflow=1. All products -33554432 with relu_en=0 → sum_out=-33554432, overflow=1.
- Abort (N_INPUTS=4): start, 2 products of 262144, then start with bias=0, then 4 products of 65536 → exactly one sum_valid, sum_out=262144.
